instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction-fetch stage (BuscInstr): owns the PC and issues word reads to the memory controller on if_mc_*.
//  Yields the RAM whenever the memory stage drives mem_mc_en.
//  Delivers {instruction, PC} to decode through a valid/stall output register plus a one-word skid buffer.
//  Redirects on taken branch/jump from execute.
// PARAMETERS
//  ADDR_W   18  word-address width (PC, if_mc_addr, branch target)
//  DATA_W   32  instruction width
//  RESET_PC 0   PC loaded on reset
//  PC_STEP  1   PC increment per fetched instruction
// PORTS
//  clock         in   1       rising-edge clock
//  reset         in   1       asynchronous, active-high reset
//  if_mc_en      out  1       fetch requests RAM this cycle
//  if_mc_addr    out  ADDR_W  fetch address (= PC)
//  mc_if_data    in   DATA_W  word returned by memory controller
//  mem_mc_en     in   1       memory stage owns RAM this cycle (priority over fetch)
//  ex_if_branch  in   1       taken branch/jump: redirect PC
//  ex_if_target  in   ADDR_W  redirect address
//  id_if_stall   in   1       decode cannot accept; hold output
//  if_id_instr   out  DATA_W  fetched instruction
//  if_id_pc      out  ADDR_W  address of if_id_instr
//  if_id_valid   out  1       if_id_instr/if_id_pc valid
// BEHAVIOUR
//  States: IDLE, REQ1, REQ2, HOLD. Reset (async): state=IDLE, pc=RESET_PC, skid buffer empty.
//   Outputs on reset: if_id_valid=0, if_id_instr=0, if_id_pc=0.
//   if_mc_en=0 in IDLE/HOLD, 1 in REQ1/REQ2 (combinational from state); if_mc_addr=pc always.
//  IDLE -> REQ1 unconditionally on first clock after reset release.
//  Access = 2 cycles (controller does two 16-bit RAM halves): REQ1 then REQ2; word sampled at REQ2 rising edge.
//  REQ1: mem_mc_en=1 -> stay REQ1 (retry); else -> REQ2.
//  REQ2: mem_mc_en=1 -> REQ1, access aborted, pc unchanged.
//   Else if output free (!if_id_valid | !id_if_stall): load if_id_instr=mc_if_data, if_id_pc=pc, valid=1.
//    pc += PC_STEP; -> REQ1.
//   Else: mc_if_data -> skid buffer (with pc); pc += PC_STEP; -> HOLD.
//  HOLD: no RAM request. When !id_if_stall: skid -> output reg (valid=1), buffer empty, -> REQ1.
//  Output reg: id_if_stall=1 holds all three outputs; !id_if_stall with no new word -> valid<=0.
//  Redirect: ex_if_branch=1 in any state (highest priority, ignores stall and mem_mc_en):
//   pc<=ex_if_target, skid emptied, if_id_valid<=0, in-flight access discarded, -> REQ1.
//  PC arithmetic mod 2^ADDR_W: 0x3FFFF + 1 -> 0x00000.
//  Best-case throughput: 1 instruction per 2 cycles. No word is ever duplicated or lost across stalls.
//  Reset mid-access: state and outputs clear immediately (async); no partial word is presented.
// TESTING
//  1 Reset release, RAM[0]=0xDEADBEEF, RAM[1]=0x12345678, no conflicts -> IDLE 1 cycle, if_mc_en=1 with addr 0.
//    valid with instr 0xDEADBEEF/pc 0 after REQ2; then 0x12345678/pc 1 two cycles later.
//  2 mem_mc_en=1 for 1 cycle during REQ2 of addr 5 -> abort, REQ1 addr 5 again.
//    valid delayed 2 cycles, pc stays 5 until success.
//  3 id_if_stall=1 for 6 cycles with valid output -> output frozen; next word enters skid; HOLD, if_mc_en=0.
//    After release: skid word on next edge, fetch resumes at following pc; sequence gap-free.
//  4 ex_if_branch=1, target 0x3FF00 during REQ2 (also with mem_mc_en=1 and id_if_stall=1) -> next edge valid=0.
//    REQ1 addr 0x3FF00; the in-flight word never appears.
//  5 pc=0x3FFFF fetch completes -> next if_mc_addr=0x00000.
//  6 reset asserted mid-REQ2 then released -> outputs 0 at once, IDLE, refetch from RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues two-cycle word reads to the memory
// controller, and delivers {instr, pc} to decode through an output register plus skid buffer.
module instr_fetch_unit #(
  parameter int unsigned         ADDR_W   = 18,
  parameter int unsigned         DATA_W   = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0,
  parameter logic [ADDR_W-1:0]   PC_STEP  = ADDR_W'(1)
) (
  input  logic              clock,
  input  logic              reset,
  output logic              if_mc_en,
  output logic [ADDR_W-1:0] if_mc_addr,
  input  logic [DATA_W-1:0] mc_if_data,
  input  logic              mem_mc_en,
  input  logic              ex_if_branch,
  input  logic [ADDR_W-1:0] ex_if_target,
  input  logic              id_if_stall,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic              if_id_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ1 = 2'd1,
    REQ2 = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  logic [DATA_W-1:0]   skid_instr;
  logic [ADDR_W-1:0]   skid_pc;
  logic                skid_valid;
  logic                out_free;

  assign if_mc_en   = (state == REQ1) || (state == REQ2);
  assign if_mc_addr = pc;
  assign out_free   = !if_id_valid || !id_if_stall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      skid_instr  <= '0;
      skid_pc     <= '0;
      skid_valid  <= 1'b0;
      if_id_instr <= '0;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
    end else if (ex_if_branch) begin
      // Redirect wins over everything: the in-flight access and any skid word are dropped.
      state       <= REQ1;
      pc          <= ex_if_target;
      skid_valid  <= 1'b0;
      if_id_valid <= 1'b0;
    end else begin
      // Consumed output with no replacement this cycle goes invalid; later loads override.
      if (!id_if_stall) if_id_valid <= 1'b0;

      case (state)
        IDLE: state <= REQ1;

        REQ1: begin
          if (!mem_mc_en) state <= REQ2;
        end

        REQ2: begin
          if (mem_mc_en) begin
            state <= REQ1;
          end else if (out_free) begin
            if_id_instr <= mc_if_data;
            if_id_pc    <= pc;
            if_id_valid <= 1'b1;
            pc          <= pc + PC_STEP;
            state       <= REQ1;
          end else begin
            skid_instr  <= mc_if_data;
            skid_pc     <= pc;
            skid_valid  <= 1'b1;
            pc          <= pc + PC_STEP;
            state       <= HOLD;
          end
        end

        HOLD: begin
          if (!id_if_stall) begin
            if_id_instr <= skid_instr;
            if_id_pc    <= skid_pc;
            if_id_valid <= skid_valid;
            skid_valid  <= 1'b0;
            state       <= REQ1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a combinational memory-controller model.
module tb_instr_fetch_unit;

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned DATA_W = 32;

  logic              clock;
  logic              reset;
  logic              if_mc_en;
  logic [ADDR_W-1:0] if_mc_addr;
  logic [DATA_W-1:0] mc_if_data;
  logic              mem_mc_en;
  logic              ex_if_branch;
  logic [ADDR_W-1:0] ex_if_target;
  logic              id_if_stall;
  logic [DATA_W-1:0] if_id_instr;
  logic [ADDR_W-1:0] if_id_pc;
  logic              if_id_valid;

  int checks   = 0;
  int failures = 0;

  instr_fetch_unit #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RESET_PC(18'h00000),
    .PC_STEP (18'h00001)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .if_mc_en    (if_mc_en),
    .if_mc_addr  (if_mc_addr),
    .mc_if_data  (mc_if_data),
    .mem_mc_en   (mem_mc_en),
    .ex_if_branch(ex_if_branch),
    .ex_if_target(ex_if_target),
    .id_if_stall (id_if_stall),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc),
    .if_id_valid (if_id_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    if (a == 18'd0)      return 32'hDEADBEEF;
    else if (a == 18'd1) return 32'h12345678;
    else                 return 32'hC0DE0000 ^ 32'(a);
  endfunction

  assign mc_if_data = mem_word(if_mc_addr);

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_mc_en = 1'b0; ex_if_branch = 1'b0; ex_if_target = '0; id_if_stall = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", if_id_valid); end
    checks++; if (if_id_instr !== '0) begin failures++; $display("FAIL reset_instr got=%0h exp=0", if_id_instr); end
    checks++; if (if_id_pc !== '0) begin failures++; $display("FAIL reset_pc got=%0h exp=0", if_id_pc); end
    checks++; if (if_mc_en !== 1'b0) begin failures++; $display("FAIL reset_idle_mc_en got=%0h exp=0", if_mc_en); end
    tick(); // IDLE -> REQ1
    checks++; if (if_mc_en !== 1'b1 || if_mc_addr !== 18'h0) begin
      failures++; $display("FAIL first_req got_en=%0h got_addr=%0h exp_en=1 exp_addr=0", if_mc_en, if_mc_addr); end
  endtask

  task automatic test_sequential_fetch();
    do_reset();
    tick(); tick(); tick(); // IDLE, REQ1, REQ2 -> word 0 loaded
    checks++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'hDEADBEEF || if_id_pc !== 18'h0) begin
      failures++; $display("FAIL fetch0 got v=%0h i=%0h pc=%0h exp v=1 i=deadbeef pc=0", if_id_valid, if_id_instr, if_id_pc); end
    tick();
    checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL fetch0_drop got=%0h exp=0", if_id_valid); end
    tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'h12345678 || if_id_pc !== 18'h1) begin
      failures++; $display("FAIL fetch1 got v=%0h i=%0h pc=%0h exp v=1 i=12345678 pc=1", if_id_valid, if_id_instr, if_id_pc); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    tick(); tick(); tick();
    for (int unsigned k = 0; k < 8; k++) begin
      checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 18'(k) || if_id_instr !== mem_word(18'(k))) begin
        failures++; $display("FAIL b2b_%0d got v=%0h i=%0h pc=%0h exp v=1 i=%0h pc=%0h",
                             k, if_id_valid, if_id_instr, if_id_pc, mem_word(18'(k)), k); end
      tick(); tick();
    end
  endtask

  task automatic test_mem_conflict();
    do_reset();
    ex_if_branch = 1'b1; ex_if_target = 18'h5;
    tick(); // REQ1 @5
    ex_if_branch = 1'b0;
    tick(); // REQ2 @5
    mem_mc_en = 1'b1;
    tick(); // abort -> REQ1
    mem_mc_en = 1'b0;
    checks++; if (if_mc_en !== 1'b1 || if_mc_addr !== 18'h5 || if_id_valid !== 1'b0) begin
      failures++; $display("FAIL abort got en=%0h addr=%0h v=%0h exp en=1 addr=5 v=0", if_mc_en, if_mc_addr, if_id_valid); end
    tick(); // REQ2
    checks++; if (if_id_valid !== 1'b0 || if_mc_addr !== 18'h5) begin
      failures++; $display("FAIL abort_req2 got v=%0h addr=%0h exp v=0 addr=5", if_id_valid, if_mc_addr); end
    tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 18'h5 || if_id_instr !== mem_word(18'h5) || if_mc_addr !== 18'h6) begin
      failures++; $display("FAIL abort_done got v=%0h i=%0h pc=%0h addr=%0h exp v=1 i=%0h pc=5 addr=6",
                           if_id_valid, if_id_instr, if_id_pc, if_mc_addr, mem_word(18'h5)); end
    // REQ1 retry: two cycles of memory-stage ownership stretch REQ1
    mem_mc_en = 1'b1;
    tick(); tick();
    mem_mc_en = 1'b0;
    tick(); // REQ1 -> REQ2
    checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL req1_retry_early got=%0h exp=0", if_id_valid); end
    tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 18'h6 || if_id_instr !== mem_word(18'h6)) begin
      failures++; $display("FAIL req1_retry got v=%0h i=%0h pc=%0h exp v=1 i=%0h pc=6", if_id_valid, if_id_instr, if_id_pc, mem_word(18'h6)); end
  endtask

  task automatic test_stall_skid();
    do_reset();
    tick(); tick(); tick(); // word 0 valid, REQ1 @1
    id_if_stall = 1'b1;
    for (int unsigned k = 0; k < 6; k++) begin
      tick();
      checks++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'hDEADBEEF || if_id_pc !== 18'h0) begin
        failures++; $display("FAIL stall_hold_%0d got v=%0h i=%0h pc=%0h exp v=1 i=deadbeef pc=0", k, if_id_valid, if_id_instr, if_id_pc); end
      if (k >= 1) begin
        checks++; if (if_mc_en !== 1'b0 || if_mc_addr !== 18'h2) begin
          failures++; $display("FAIL stall_hold_mc_%0d got en=%0h addr=%0h exp en=0 addr=2", k, if_mc_en, if_mc_addr); end
      end
    end
    id_if_stall = 1'b0;
    tick(); // skid -> output
    checks++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'h12345678 || if_id_pc !== 18'h1 || if_mc_en !== 1'b1) begin
      failures++; $display("FAIL skid_out got v=%0h i=%0h pc=%0h en=%0h exp v=1 i=12345678 pc=1 en=1", if_id_valid, if_id_instr, if_id_pc, if_mc_en); end
    tick(); tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 18'h2 || if_id_instr !== mem_word(18'h2)) begin
      failures++; $display("FAIL after_skid got v=%0h i=%0h pc=%0h exp v=1 i=%0h pc=2", if_id_valid, if_id_instr, if_id_pc, mem_word(18'h2)); end
  endtask

  task automatic test_branch();
    do_reset();
    tick(); tick(); tick(); tick(); // REQ2 @1, word 0 dropped
    id_if_stall = 1'b1; mem_mc_en = 1'b1; ex_if_branch = 1'b1; ex_if_target = 18'h3FF00;
    tick();
    id_if_stall = 1'b0; mem_mc_en = 1'b0; ex_if_branch = 1'b0;
    checks++; if (if_id_valid !== 1'b0 || if_mc_en !== 1'b1 || if_mc_addr !== 18'h3FF00) begin
      failures++; $display("FAIL branch_req2 got v=%0h en=%0h addr=%0h exp v=0 en=1 addr=3ff00", if_id_valid, if_mc_en, if_mc_addr); end
    tick(); tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 18'h3FF00 || if_id_instr !== mem_word(18'h3FF00)) begin
      failures++; $display("FAIL branch_word got v=%0h i=%0h pc=%0h exp v=1 i=%0h pc=3ff00", if_id_valid, if_id_instr, if_id_pc, mem_word(18'h3FF00)); end
    // branch while a word sits in the skid buffer: that word must vanish
    do_reset();
    tick(); tick(); tick();
    id_if_stall = 1'b1;
    tick(); tick(); tick(); // HOLD with skid = word 1
    ex_if_branch = 1'b1; ex_if_target = 18'h10;
    tick();
    ex_if_branch = 1'b0; id_if_stall = 1'b0;
    checks++; if (if_id_valid !== 1'b0 || if_mc_addr !== 18'h10 || if_mc_en !== 1'b1) begin
      failures++; $display("FAIL branch_hold got v=%0h en=%0h addr=%0h exp v=0 en=1 addr=10", if_id_valid, if_mc_en, if_mc_addr); end
    tick();
    checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL branch_hold_skid got v=%0h pc=%0h exp v=0", if_id_valid, if_id_pc); end
    tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 18'h10 || if_id_instr !== mem_word(18'h10)) begin
      failures++; $display("FAIL branch_hold_word got v=%0h i=%0h pc=%0h exp v=1 i=%0h pc=10", if_id_valid, if_id_instr, if_id_pc, mem_word(18'h10)); end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    ex_if_branch = 1'b1; ex_if_target = 18'h3FFFF;
    tick();
    ex_if_branch = 1'b0;
    tick(); tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 18'h3FFFF || if_id_instr !== mem_word(18'h3FFFF) || if_mc_addr !== 18'h0) begin
      failures++; $display("FAIL pc_wrap got v=%0h pc=%0h addr=%0h exp v=1 pc=3ffff addr=0", if_id_valid, if_id_pc, if_mc_addr); end
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    tick(); tick(); tick();
    id_if_stall = 1'b1;
    tick(); // REQ2, word 0 held valid
    #2 reset = 1'b1;
    #1;
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== '0 || if_id_pc !== '0 || if_mc_en !== 1'b0 || if_mc_addr !== 18'h0) begin
      failures++; $display("FAIL async_reset got v=%0h i=%0h pc=%0h en=%0h addr=%0h exp all 0",
                           if_id_valid, if_id_instr, if_id_pc, if_mc_en, if_mc_addr); end
    tick();
    reset = 1'b0; id_if_stall = 1'b0;
    tick(); tick(); tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 18'h0 || if_id_instr !== 32'hDEADBEEF) begin
      failures++; $display("FAIL refetch got v=%0h i=%0h pc=%0h exp v=1 i=deadbeef pc=0", if_id_valid, if_id_instr, if_id_pc); end
  endtask

  initial begin
    reset = 1'b1; mem_mc_en = 1'b0; ex_if_branch = 1'b0; ex_if_target = '0; id_if_stall = 1'b0;
    test_reset();
    test_sequential_fetch();
    test_back_to_back();
    test_mem_conflict();
    test_stall_skid();
    test_branch();
    test_pc_wrap();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
